// File: rtl/jtag_ocimem_pkg.sv
// Shared definitions for the JTAG OCI memory controller: jdo field map,
// FSM state encoding and pending-command encoding.
package jtag_ocimem_pkg;

    localparam int unsigned JDO_W      = 38;
    localparam int unsigned ADDR_LSB   = 17;
    localparam int unsigned RD_NOW_BIT = 26;
    localparam int unsigned WDATA_LSB  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StJCap,
        StCRd
    } state_e;

    typedef enum logic [1:0] {
        OpNone,
        OpRd,
        OpRdInc,
        OpWr
    } pend_op_e;

    function automatic logic is_read(input pend_op_e op);
        return (op == OpRd) || (op == OpRdInc);
    endfunction

endpackage

// File: rtl/jtag_ocimem_ram.sv
// Single-port debug RAM, 32-bit words with byte enables and a registered read.
// A read of the address being written returns the previous contents.
module jtag_ocimem_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [31:0] mem [Depth];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jtag_ocimem_ctrl.sv
// Executes JTAG OCI memory commands against a private debug RAM and shares that
// RAM with the CPU over an Avalon-MM slave; JTAG work wins same-cycle contention.
module jtag_ocimem_ctrl
    import jtag_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              cmd_overrun
);

    state_e            state_q, state_d;
    pend_op_e          pend_op_q, pend_op_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [DATA_W-1:0] mon_d_q, mon_d_d;
    logic              overrun_q, overrun_d;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;
    logic              cpu_grant;
    logic              jtag_rd_done;
    logic              jtag_wr_done;
    logic              pend_rd;
    logic              any_strobe;
    logic              unused_jdo;

    assign pend_rd    = is_read(pend_op_q);
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[JDO_W-1:WDATA_LSB+DATA_W], jdo[WDATA_LSB-1:0]};

    jtag_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pend_rd) begin
                    state_d = StJCap;
                end else if ((pend_op_q == OpNone) && !avs_write && avs_read) begin
                    state_d = StCRd;
                end
            end
            StJCap:  state_d = StIdle;
            StCRd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A strobe landing on a completion edge is dropped, so the IDLE cycle after any
    // JTAG op always has pending empty and a waiting CPU request gets served there.
    always_comb begin
        ram_addr     = mon_a_q;
        ram_we       = 1'b0;
        ram_be       = 4'h0;
        ram_wdata    = pend_data_q;
        cpu_grant    = 1'b0;
        jtag_rd_done = 1'b0;
        jtag_wr_done = 1'b0;
        avs_readdata = '0;
        unique case (state_q)
            StIdle: begin
                if (pend_rd) begin
                    ram_addr = mon_a_q;
                end else if (pend_op_q == OpWr) begin
                    ram_we       = 1'b1;
                    ram_be       = 4'hF;
                    jtag_wr_done = 1'b1;
                end else if (avs_write) begin
                    ram_addr  = avs_address;
                    ram_we    = 1'b1;
                    ram_be    = avs_byteenable;
                    ram_wdata = avs_writedata;
                    cpu_grant = 1'b1;
                end else if (avs_read) begin
                    ram_addr = avs_address;
                end
            end
            StJCap: begin
                jtag_rd_done = 1'b1;
            end
            StCRd: begin
                avs_readdata = ram_q;
                cpu_grant    = avs_read;
            end
            default: ;
        endcase
    end

    assign avs_waitrequest = (avs_read | avs_write) & ~cpu_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_op_q   <= OpNone;
            pend_data_q <= '0;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            pend_op_q   <= pend_op_d;
            pend_data_q <= pend_data_d;
            mon_a_q     <= mon_a_d;
            mon_d_q     <= mon_d_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        pend_op_d   = pend_op_q;
        pend_data_d = pend_data_q;
        mon_a_d     = mon_a_q;
        mon_d_d     = mon_d_q;
        overrun_d   = overrun_q;

        if (jtag_rd_done) begin
            mon_d_d   = ram_q;
            pend_op_d = OpNone;
            if (pend_op_q == OpRdInc) begin
                mon_a_d = mon_a_q + ADDR_W'(1);
            end
        end
        if (jtag_wr_done) begin
            mon_a_d   = mon_a_q + ADDR_W'(1);
            pend_op_d = OpNone;
        end

        // Capture only into an empty slot; completion and capture never share an edge.
        if (any_strobe) begin
            if (pend_op_q != OpNone) begin
                overrun_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                mon_a_d = jdo[ADDR_LSB +: ADDR_W];
                if (jdo[RD_NOW_BIT]) begin
                    pend_op_d = OpRd;
                end
                if (take_action_ocimem_b | take_no_action_ocimem_a) begin
                    overrun_d = 1'b1;
                end
            end else if (take_action_ocimem_b) begin
                pend_op_d   = OpWr;
                pend_data_d = jdo[WDATA_LSB +: DATA_W];
                if (take_no_action_ocimem_a) begin
                    overrun_d = 1'b1;
                end
            end else begin
                pend_op_d = OpRdInc;
            end
        end
    end

    assign MonDReg     = mon_d_q;
    assign MonAReg     = mon_a_q;
    assign cmd_overrun = overrun_q;

endmodule

// File: tb/tb_jtag_ocimem_ctrl.sv
// Bench for jtag_ocimem_ctrl: a vector table of JTAG/CPU operations with a
// result scoreboard, followed by contention, overrun and reset sequences.
module tb_jtag_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tna_a;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        cmd_overrun;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    jtag_ocimem_ctrl #(
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .cmd_overrun             (cmd_overrun)
    );

    typedef enum int {VSetA, VJWr, VJRd, VJRdInc, VCWr, VCRd} vop_e;

    typedef struct {
        vop_e        op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_d;
        logic [7:0]  exp_a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input vop_e op, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [31:0] ed,
                                input logic [7:0] ea);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.be = be; v.exp_d = ed; v.exp_a = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [31:0] act);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got 0x%08h, expected nothing (scoreboard empty)", name, act);
        end else begin
            exp = sb_q.pop_front();
            chk(name, act, exp);
        end
    endtask

    // Strobe one JTAG command, then check results two edges after the strobe edge.
    task automatic jtag_op(input vec_t v);
        jdo = '0;
        case (v.op)
            VSetA: begin jdo[24:17] = v.addr; ta_a = 1'b1; end
            VJRd: begin
                jdo[24:17] = v.addr; jdo[26] = 1'b1; ta_a = 1'b1;
                sb_q.push_back(v.exp_d);
            end
            VJWr: begin jdo[34:3] = v.data; ta_b = 1'b1; end
            default: begin tna_a = 1'b1; sb_q.push_back(v.exp_d); end
        endcase
        @(posedge clk); #1;
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0; jdo = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (v.op == VJRd || v.op == VJRdInc) sb_check("jtag_mondreg", MonDReg);
        chk("jtag_monareg", 32'(MonAReg), 32'(v.exp_a));
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        #1;
        chk("cpu_wr_waitreq", 32'(avs_waitrequest), 32'd0);
        @(posedge clk); #1;
        avs_write = 1'b0; avs_byteenable = 4'h0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, output int waits);
        bit done = 1'b0;
        avs_address = a; avs_read = 1'b1;
        sb_q.push_back(exp);
        waits = 0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (!avs_waitrequest) begin
                sb_check("cpu_readdata", avs_readdata);
                done = 1'b1;
                break;
            end
            waits++;
            @(posedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL cpu_read_timeout: waitrequest still 1 after %0d cycles, required 0", waits);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        avs_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    initial begin
        int w;
        reset = 1'b1; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = 4'h0;

        vecs.push_back(mk(VSetA,   8'h10, 0,            4'h0, 0,            8'h10));
        vecs.push_back(mk(VJWr,    8'h00, 32'hDEADBEEF, 4'h0, 0,            8'h11));
        vecs.push_back(mk(VJRd,    8'h10, 0,            4'h0, 32'hDEADBEEF, 8'h10));
        vecs.push_back(mk(VCWr,    8'h30, 32'h11111111, 4'hF, 0,            8'h10));
        vecs.push_back(mk(VCWr,    8'h30, 32'h0000AB00, 4'h2, 0,            8'h10));
        vecs.push_back(mk(VCRd,    8'h30, 0,            4'h0, 32'h1111AB11, 8'h10));
        vecs.push_back(mk(VCWr,    8'hFE, 32'h1,        4'hF, 0,            8'h10));
        vecs.push_back(mk(VCWr,    8'hFF, 32'h2,        4'hF, 0,            8'h10));
        vecs.push_back(mk(VCWr,    8'h00, 32'h3,        4'hF, 0,            8'h10));
        vecs.push_back(mk(VSetA,   8'hFE, 0,            4'h0, 0,            8'hFE));
        vecs.push_back(mk(VJRdInc, 8'h00, 0,            4'h0, 32'h1,        8'hFF));
        vecs.push_back(mk(VJRdInc, 8'h00, 0,            4'h0, 32'h2,        8'h00));
        vecs.push_back(mk(VJRdInc, 8'h00, 0,            4'h0, 32'h3,        8'h01));
        vecs.push_back(mk(VCRd,    8'h10, 0,            4'h0, 32'hDEADBEEF, 8'h01));
        vecs.push_back(mk(VSetA,   8'h40, 0,            4'h0, 0,            8'h40));
        vecs.push_back(mk(VJWr,    8'h00, 32'hCAFEF00D, 4'h0, 0,            8'h41));
        vecs.push_back(mk(VJRd,    8'h40, 0,            4'h0, 32'hCAFEF00D, 8'h40));
        vecs.push_back(mk(VCRd,    8'h40, 0,            4'h0, 32'hCAFEF00D, 8'h40));

        @(negedge clk);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_monareg", 32'(MonAReg), 32'h0);
        chk("rst_overrun", 32'(cmd_overrun), 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_waitreq", 32'(avs_waitrequest), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                VCWr: cpu_write(vecs[i].addr, vecs[i].data, vecs[i].be);
                VCRd: begin
                    cpu_read(vecs[i].addr, vecs[i].exp_d, w);
                    chk("cpu_rd_waits", 32'(w), 32'd1);
                end
                default: jtag_op(vecs[i]);
            endcase
        end

        // Pending JTAG write and CPU read to the same word in the same cycle.
        jtag_op(mk(VSetA, 8'h20, 0, 4'h0, 0, 8'h20));
        jdo = '0; jdo[34:3] = 32'h12345678; ta_b = 1'b1;
        @(posedge clk); #1;
        ta_b = 1'b0; jdo = '0;
        cpu_read(8'h20, 32'h12345678, w);
        chk("contend_waits", 32'(w), 32'd2);
        chk("contend_monareg", 32'(MonAReg), 32'h21);

        // Simultaneous strobes: address loads, write is dropped, overrun sticks.
        chk("pre_overrun", 32'(cmd_overrun), 32'h0);
        cpu_write(8'h50, 32'h55555555, 4'hF);
        jdo = '0; jdo[24:17] = 8'h50; ta_a = 1'b1; ta_b = 1'b1;
        @(posedge clk); #1;
        ta_a = 1'b0; ta_b = 1'b0; jdo = '0;
        @(negedge clk);
        chk("ovr_monareg", 32'(MonAReg), 32'h50);
        chk("ovr_flag", 32'(cmd_overrun), 32'h1);
        cpu_read(8'h50, 32'h55555555, w);
        chk("ovr_rd_waits", 32'(w), 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ovr_sticky", 32'(cmd_overrun), 32'h1);

        // Reset while the read is in J_CAP.
        jdo = '0; jdo[24:17] = 8'h10; jdo[26] = 1'b1; ta_a = 1'b1;
        @(posedge clk); #1;
        ta_a = 1'b0; jdo = '0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("jcap_rst_mondreg", MonDReg, 32'h0);
        chk("jcap_rst_monareg", 32'(MonAReg), 32'h0);
        chk("jcap_rst_overrun", 32'(cmd_overrun), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("jcap_no_stale_rd", MonDReg, 32'h0);
        cpu_read(8'h10, 32'hDEADBEEF, w);
        chk("jcap_rst_rd_waits", 32'(w), 32'd1);
        @(negedge clk);
        jtag_op(mk(VJRd, 8'h10, 0, 4'h0, 32'hDEADBEEF, 8'h10));

        // A strobe on the edge that retires a pending write is dropped.
        jdo = '0; jdo[34:3] = 32'hA5A5A5A5; ta_b = 1'b1;
        @(posedge clk); #1;
        ta_b = 1'b0; jdo = '0; tna_a = 1'b1;
        @(posedge clk); #1;
        tna_a = 1'b0;
        @(negedge clk);
        chk("full_overrun", 32'(cmd_overrun), 32'h1);
        chk("full_monareg", 32'(MonAReg), 32'h11);
        @(posedge clk);
        @(negedge clk);
        chk("full_mondreg", MonDReg, 32'hDEADBEEF);
        cpu_read(8'h10, 32'hA5A5A5A5, w);
        chk("full_rd_waits", 32'(w), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_ocimem_ctrl.md
Name: jtag_ocimem_ctrl

Overview:
System-clock-domain consumer of the JTAG debug module's decoded action strobes and the 38-bit jdo shift-register snapshot. It executes OCI memory commands (address load, read, write, streaming read with auto-increment) against a private 256x32 debug RAM. The read result is returned to the TCK side as MonDReg. The same RAM is exposed to the CPU through an Avalon-MM slave port, and this block arbitrates between the JTAG and CPU sides.

Parameters:
ADDR_W, 8, debug RAM word-address width; RAM depth = 2**ADDR_W
DATA_W, 32, RAM word width; fixed at 32 (MonDReg width)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
jdo  in  38  JTAG data snapshot; [ADDR_W+16:17]=address, [26]=read-now, [34:3]=write data
take_action_ocimem_a  in  1  1-cycle strobe: load MonAReg from jdo; read if jdo[26]
take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at MonAReg, then increment
take_no_action_ocimem_a  in  1  1-cycle strobe: read at MonAReg, then increment
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  CPU stall
MonDReg  out  32  last JTAG read result
MonAReg  out  ADDR_W  current JTAG word address
cmd_overrun  out  1  sticky: a JTAG command was dropped

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, pending cleared, overrun cleared. RAM contents are not reset.
- Reset asserted mid-operation: return to IDLE immediately; any in-flight JTAG or CPU transaction is abandoned.
- Command capture, at the strobe edge E0:
  - The strobe loads a 1-deep pending register {op, data}.
  - ocimem_a also loads MonAReg at E0, so the address update is never delayed.
  - ocimem_a with jdo[26]=0 loads the address only; pending is not set.
- Simultaneous strobes: priority ocimem_a > ocimem_b > no_action_a. Losers are dropped and cmd_overrun=1.
- Pending full: a strobe arriving while pending is still set is dropped and sets cmd_overrun; it clears only on reset.
- FSM states: IDLE, J_CAP, C_RD.
- IDLE with pending read:
  - Drive RAM address=MonAReg; go to J_CAP.
  - At the J_CAP exit edge: MonDReg <= RAM q, MonAReg++ (no_action_a only), clear pending, go to IDLE.
  - MonDReg is therefore valid after E2 (2 edges after the strobe edge).
- IDLE with pending write:
  - Write the full word at MonAReg in that cycle.
  - At the next edge: MonAReg++, pending cleared; stay in IDLE.
- IDLE, no pending, avs_write: avs_waitrequest=0 in the same cycle; byte-enabled write.
- IDLE, no pending, avs_read: drive avs_address to the RAM; avs_waitrequest=1; go to C_RD.
- C_RD: avs_readdata = RAM q, avs_waitrequest=0; return to IDLE. Pending JTAG work waits until IDLE.
- Arbitration: JTAG pending beats a CPU request in the same IDLE cycle. The CPU sees avs_waitrequest=1 whenever it is not granted.
- CPU is never starved: after a JTAG op completes, a waiting CPU request is served before the next pending op.
- avs_waitrequest=1 whenever avs_read|avs_write is asserted and not granted this cycle.
- MonAReg increments modulo 2**ADDR_W (0xFF -> 0x00).
- RAM has synchronous read with 1-cycle latency; read-during-write to the same address returns old data.

Decomposition:
- Shared package jtag_ocimem_pkg holds:
  - jdo field positions (ADDR_LSB=17, RD_NOW_BIT=26, WDATA_LSB=3)
  - FSM state enum
  - pending-op enum {NONE, RD, RD_INC, WR}
- One sub-module: jtag_ocimem_ram, a single-port 2**ADDR_W x 32 RAM with byte enables and synchronous read.

Test Plan:
- Write then read back:
  - ocimem_a with addr=0x10, jdo[26]=0; then ocimem_b with data 0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, MonAReg=0x11.
  - ocimem_a with addr=0x10, read-now -> MonDReg=0xDEADBEEF two edges after the strobe.
- Streaming read: preload RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3; ocimem_a to 0xFE (no read); three no_action_a strobes 3 cycles apart -> MonDReg 1,2,3; MonAReg wraps to 0x01.
- Contention: avs_read at 0x20 in the same cycle as a pending JTAG write to 0x20 -> JTAG write first; CPU read returns the new data; avs_waitrequest high for 2 cycles.
- Overrun: ocimem_a and ocimem_b in the same cycle -> address loaded, write dropped, cmd_overrun=1 and stays 1 until reset.
- CPU byte write: avs_write with be=4'b0010 and data 0x0000AB00 onto 0x11111111 -> word reads back 0x1111AB11; waitrequest=0 on the write cycle.
- Reset in J_CAP -> MonDReg=0, FSM=IDLE, pending cleared, RAM contents preserved.
